// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmitter.
// Build option PISO_PARITY_EN (see piso_serializer.sv) does not affect this file.
package piso_pkg;

    localparam int unsigned PISO_DEFAULT_WIDTH = 6;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } piso_state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bus of the serializer: producer handshake plus serial link outputs.
// Build option PISO_PARITY_EN does not change this interface.
interface piso_serializer_if
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             done;

    // Producer/observer side.
    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  serial_out,
        input  serial_valid,
        input  done
    );

    // Serializer side.
    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output serial_out,
        output serial_valid,
        output done
    );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter, MSB first, back-to-back words without gaps.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_DEFAULT_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    piso_serializer_if.slave    bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH);
`else
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);
`endif

    piso_state_e      state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CntW-1:0]  cnt_q;
`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif

    logic last_bit;
    logic load_ready;
    logic accept;
    logic bit_out;

    assign last_bit   = (state_q == StShift) && (cnt_q == LastIdx);
    assign load_ready = (state_q == StIdle) || last_bit;
    assign accept     = bus.load_valid && load_ready;

    always_comb begin
        bit_out = 1'b0;
        if (state_q == StShift) begin
`ifdef PISO_PARITY_EN
            bit_out = (cnt_q == LastIdx) ? parity_q : shreg_q[WIDTH-1];
`else
            bit_out = shreg_q[WIDTH-1];
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            cnt_q    <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (accept) begin
            // Covers both a fresh load from idle and a seamless reload on the last bit.
            state_q  <= StShift;
            shreg_q  <= bus.data_in;
            cnt_q    <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= ^bus.data_in;
`endif
        end else if (state_q == StShift) begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            if (last_bit) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign bus.load_ready   = load_ready;
    assign bus.serial_out   = bit_out;
    assign bus.serial_valid = (state_q == StShift);
    assign bus.done         = last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: directed and random words against a bit-stream model and a loopback SIPO.
// Compile with PISO_PARITY_EN defined to check the parity variant.
module tb_piso_serializer;
    import piso_pkg::*;

    localparam int W = PISO_DEFAULT_WIDTH;
`ifdef PISO_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clock;
    logic reset;
    logic [W-1:0] sipo_q;
    int checks;
    int failures;

    piso_serializer_if #(.WIDTH(W)) bus ();

    piso_serializer #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Receiving end of the link.
    always @(posedge clock or posedge reset) begin
        if (reset) sipo_q <= '0;
        else if (bus.serial_valid) sipo_q <= {sipo_q[W-2:0], bus.serial_out};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, bus.serial_valid, 0);
        chk({tag, "_out"}, bus.serial_out, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_ready"}, bus.load_ready, 1);
    endtask

    // Called at edge+1 in idle; returns at edge+1 of the first bit cycle.
    task automatic load(input logic [W-1:0] w);
        chk_idle("pre_load");
        bus.load_valid = 1'b1;
        bus.data_in    = w;
        @(posedge clock);
        #1;
        bus.load_valid = 1'b0;
        bus.data_in    = W'($urandom);
    endtask

    task automatic do_abort();
        #2 reset = 1'b1;
        #1 chk_idle("async_rst");
        @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Checks one word's bit cycles; optionally chains the next word, pokes a busy load or aborts.
    task automatic expect_word(input logic [W-1:0] w, input bit chain, input logic [W-1:0] nxt,
                               input int junk_cyc, input logic [W-1:0] junk, input int abort_at);
        for (int c = 1; c <= NB; c++) begin
            logic expb;
            expb = (c <= W) ? w[W-c] : ^w;
            chk("valid", bus.serial_valid, 1);
            chk("bit", bus.serial_out, expb);
            chk("done", bus.done, (c == NB));
            chk("ready", bus.load_ready, (c == NB));
            if (c == abort_at) begin
                do_abort();
                return;
            end
            if (c == NB && chain) begin
                bus.load_valid = 1'b1;
                bus.data_in    = nxt;
            end else if (c == junk_cyc) begin
                bus.load_valid = 1'b1;
                bus.data_in    = junk;
            end else begin
                bus.load_valid = 1'b0;
                bus.data_in    = W'($urandom);
            end
            @(posedge clock);
            #1;
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic chk_loop(input logic [W-1:0] w);
`ifdef PISO_PARITY_EN
        chk("loopback", sipo_q, {w[W-2:0], ^w});
`else
        chk("loopback", sipo_q, w);
`endif
    endtask

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] nxt;
        bit chain;
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus.load_valid = 1'b0;
        bus.data_in    = '0;
        @(posedge clock);
        #1 chk_idle("reset");
        #2 reset = 1'b0;
        @(posedge clock);
        #1;

        // Basic word.
        load(6'b101101);
        expect_word(6'b101101, 1'b0, '0, 0, '0, 0);
        chk_idle("idle_after_basic");
        chk_loop(6'b101101);

        // Loopback.
        load(6'b110010);
        expect_word(6'b110010, 1'b0, '0, 0, '0, 0);
        chk_loop(6'b110010);

        // Back-to-back.
        load(6'b111000);
        expect_word(6'b111000, 1'b1, 6'b010101, 0, '0, 0);
        expect_word(6'b010101, 1'b0, '0, 0, '0, 0);
        chk_idle("idle_after_b2b");
        chk_loop(6'b010101);

        // Busy load ignored.
        load(6'b100001);
        expect_word(6'b100001, 1'b0, '0, 3, 6'b011110, 0);
        chk_idle("idle_after_busy");
        @(posedge clock);
        #1 chk_idle("busy_not_sent");

        // Async reset mid-word, then a clean word.
        load(6'b110110);
        expect_word(6'b110110, 1'b0, '0, 0, '0, 3);
        chk_idle("post_abort");
        chk("sipo_cleared", sipo_q, 0);
        load(6'b000111);
        expect_word(6'b000111, 1'b0, '0, 0, '0, 0);
        chk_loop(6'b000111);

        // Parity-relevant word (parity 1).
        load(6'b100000);
        expect_word(6'b100000, 1'b0, '0, 0, '0, 0);
        chk_loop(6'b100000);

        // Random bursts.
        for (int n = 0; n < 20; n++) begin
            w = W'($urandom);
            load(w);
            for (int k = 0; k < 4; k++) begin
                chain = (k < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
                nxt   = W'($urandom);
                expect_word(w, chain, nxt, int'($urandom_range(0, NB - 1)), W'($urandom), 0);
                if (!chain) break;
                w = nxt;
            end
            chk_idle("rand_idle");
            chk_loop(w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
